// File: rtl/spi_slave_rx.sv
// LSB-first SPI receiver: synchronises sclk/cs/mosi into clk, rebuilds each frame
// and presents it on a valid/ready port, flagging bad-length and unconsumed frames.
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int LEAD_EDGES  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int BCW = $clog2(DATA_W + 2);
    localparam int LCW = (LEAD_EDGES < 2) ? 1 : $clog2(LEAD_EDGES + 1);
    localparam logic [BCW-1:0] BIT_FULL = BCW'(DATA_W);
    localparam logic [BCW-1:0] BIT_SAT  = BCW'(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, END} state_t;
    localparam state_t START = (LEAD_EDGES == 0) ? SHIFT : LEAD;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_hist, cs_hist, mosi_hist;
    logic                   sclk_fall, cs_fall, cs_rise;

    state_t                 state, state_n;
    logic [DATA_W-1:0]      shreg;
    logic [BCW-1:0]         bit_cnt;
    logic [LCW-1:0]         lead_cnt;
    logic                   lead_last;
    logic                   frame_good, frame_bad, load;

    function automatic logic [BCW-1:0] sat_inc(input logic [BCW-1:0] c);
        return (c == BIT_SAT) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_hist <= 1'b0;
            cs_hist   <= 1'b0;
            mosi_hist <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            cs_hist   <= cs_sync[SYNC_STAGES-1];
            mosi_hist <= mosi_sync[SYNC_STAGES-1];
        end
    end

    // mosi_hist is the data value seen alongside the last high sclk sample
    assign sclk_fall = sclk_hist & ~sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_hist & ~cs_sync[SYNC_STAGES-1];
    assign cs_rise   = ~cs_hist & cs_sync[SYNC_STAGES-1];
    assign lead_last = (lead_cnt == LCW'(LEAD_EDGES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cs_fall) state_n = START;
            LEAD: begin
                if (cs_rise)                      state_n = END;
                else if (sclk_fall && lead_last)  state_n = SHIFT;
            end
            SHIFT:   if (cs_rise) state_n = END;
            END:     state_n = cs_fall ? START : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            lead_cnt <= '0;
        end else begin
            case (state)
                IDLE, END: begin
                    if (cs_fall) begin
                        bit_cnt  <= '0;
                        lead_cnt <= '0;
                    end
                end
                LEAD: begin
                    if (!cs_rise && sclk_fall) lead_cnt <= lead_cnt + 1'b1;
                end
                SHIFT: begin
                    if (!cs_rise && sclk_fall) begin
                        shreg   <= {mosi_hist, shreg[DATA_W-1:1]};
                        bit_cnt <= sat_inc(bit_cnt);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outcome of a frame is decided in the single END cycle
    assign frame_good = (state == END) && (bit_cnt == BIT_FULL);
    assign frame_bad  = (state == END) && (bit_cnt != BIT_FULL);
    assign load       = frame_good && (!dout_valid || dout_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= frame_bad;
            overrun   <= frame_good && dout_valid && !dout_ready;
            if (load) begin
                dout       <= shreg;
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: drives LSB-first SPI frames with 11-clk sclk phases and
// compares received words and error pulses against a frame-level model.
module tb_spi_slave_rx;

    localparam int DATA_W = 12;
    localparam int HALF   = 11;
    localparam int LEADS  = 1;

    logic              clk = 1'b0;
    logic              rst_n, sclk, cs, mosi, dout_ready;
    logic [DATA_W-1:0] dout;
    logic              dout_valid, frame_err, overrun;

    spi_slave_rx #(.DATA_W(DATA_W), .LEAD_EDGES(LEADS), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                n_err = 0, n_ovr = 0, n_vrise = 0, n_vfall = 0, vrise_cyc = 0;
    logic              valid_prev = 1'b0;
    logic [DATA_W-1:0] got_q[$];

    always @(negedge clk) begin
        if (dout_valid && dout_ready) got_q.push_back(dout);
        if (frame_err) n_err++;
        if (overrun) n_ovr++;
        if (dout_valid && !valid_prev) begin
            n_vrise++;
            vrise_cyc = cyc;
        end
        if (!dout_valid && valid_prev) n_vfall++;
        valid_prev = dout_valid;
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sclk_edge(input logic b);
        mosi = b;
        tick(HALF);
        sclk = 1'b0;
        tick(HALF);
        sclk = 1'b1;
    endtask

    task automatic frame_body(input logic [DATA_W-1:0] w, input int nbits);
        cs = 1'b0;
        for (int i = 0; i < LEADS; i++) sclk_edge(1'b0);
        for (int i = 0; i < nbits; i++) sclk_edge(w[i % DATA_W]);
    endtask

    int cs_rise_cyc = 0;

    task automatic frame_close(input int gap);
        tick(HALF);
        cs = 1'b1;
        cs_rise_cyc = cyc;
        tick(gap);
    endtask

    task automatic send(input logic [DATA_W-1:0] w, input int nbits, input int gap);
        frame_body(w, nbits);
        frame_close(gap);
    endtask

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] w, exp_word;
    int e0, o0, r0, f0, g0, exp_err, exp_ovr, nb, gap;
    logic pending;

    initial begin
        rst_n = 1'b0; cs = 1'b1; sclk = 1'b1; mosi = 1'b0; dout_ready = 1'b1;
        tick(3);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        tick(6);

        // single good frame
        e0 = n_err; o0 = n_ovr; g0 = got_q.size();
        send(12'hA5C, DATA_W, 20);
        check("t1_count", got_q.size() - g0, 1);
        check("t1_word", got_q[$], 12'hA5C);
        check("t1_err", n_err - e0, 0);
        check("t1_ovr", n_ovr - o0, 0);
        check("t1_latency", vrise_cyc - cs_rise_cyc, 4);

        // short frame then good frame
        e0 = n_err; r0 = n_vrise;
        send(12'h3C3, 7, 20);
        check("t2_err", n_err - e0, 1);
        check("t2_novalid", n_vrise - r0, 0);
        send(12'h3C3, DATA_W, 20);
        check("t2_word", got_q[$], 12'h3C3);

        // overrun with consumer stalled
        dout_ready = 1'b0;
        e0 = n_err; o0 = n_ovr;
        send(12'h001, DATA_W, 20);
        send(12'hFFF, DATA_W, 20);
        check("t3_dout", dout, 12'h001);
        check("t3_valid", dout_valid, 1);
        check("t3_ovr", n_ovr - o0, 1);
        check("t3_err", n_err - e0, 0);
        dout_ready = 1'b1;
        tick(2);
        check("t3_drop", dout_valid, 0);
        check("t3_word", got_q[$], 12'h001);

        // accept coincides with reload in the END cycle
        dout_ready = 1'b0;
        send(12'h123, DATA_W, 20);
        o0 = n_ovr; f0 = n_vfall;
        frame_body(12'h456, DATA_W);
        tick(HALF);
        cs = 1'b1;
        tick(3);
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        tick(10);
        check("t4_dout", dout, 12'h456);
        check("t4_valid", dout_valid, 1);
        check("t4_nogap", n_vfall - f0, 0);
        check("t4_ovr", n_ovr - o0, 0);
        check("t4_acc", got_q[$], 12'h123);
        dout_ready = 1'b1;
        tick(3);
        check("t4_word", got_q[$], 12'h456);

        // reset after 5 bits of a frame
        e0 = n_err; o0 = n_ovr; r0 = n_vrise;
        w = 12'hABC;
        cs = 1'b0;
        sclk_edge(1'b0);
        for (int i = 0; i < 5; i++) sclk_edge(w[i]);
        tick(3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_dout", dout, 0);
        check("t5_rst_valid", dout_valid, 0);
        tick(2);
        rst_n = 1'b1;
        for (int i = 5; i < DATA_W; i++) sclk_edge(w[i]);
        frame_close(20);
        check("t5_err", n_err - e0, 0);
        check("t5_novalid", n_vrise - r0, 0);
        send(12'h0F0, DATA_W, 20);
        check("t5_word", got_q[$], 12'h0F0);

        // reset released while cs stays low mid-frame
        e0 = n_err; o0 = n_ovr; r0 = n_vrise;
        w = 12'h777;
        cs = 1'b0;
        sclk_edge(1'b0);
        for (int i = 0; i < 4; i++) sclk_edge(w[i]);
        rst_n = 1'b0;
        tick(4);
        rst_n = 1'b1;
        for (int i = 4; i < DATA_W; i++) sclk_edge(w[i]);
        frame_close(20);
        send(12'h5A5, DATA_W, 20);
        check("t6_err", n_err - e0, 0);
        check("t6_ovr", n_ovr - o0, 0);
        check("t6_one", n_vrise - r0, 1);
        check("t6_word", got_q[$], 12'h5A5);

        // random frames, consumer always ready, some back-to-back
        exp_q.delete();
        exp_err = 0;
        e0 = n_err; o0 = n_ovr; g0 = got_q.size();
        for (int k = 0; k < 16; k++) begin
            w   = DATA_W'($urandom);
            nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : DATA_W;
            gap = ($urandom_range(0, 1) == 0) ? 1 : 12;
            if (nb == DATA_W) exp_q.push_back(w);
            else exp_err++;
            send(w, nb, gap);
        end
        tick(20);
        check("ra_count", got_q.size() - g0, exp_q.size());
        check("ra_err", n_err - e0, exp_err);
        check("ra_ovr", n_ovr - o0, 0);
        for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++)
            check("ra_word", got_q[g0 + i], exp_q[i]);

        // random frames, consumer stalled
        dout_ready = 1'b0;
        pending = 1'b0; exp_word = '0; exp_err = 0; exp_ovr = 0;
        e0 = n_err; o0 = n_ovr;
        for (int k = 0; k < 6; k++) begin
            w  = DATA_W'($urandom);
            nb = (k == 0 || $urandom_range(0, 2) != 0) ? DATA_W : int'($urandom_range(0, 15));
            if (nb != DATA_W) exp_err++;
            else if (pending) exp_ovr++;
            else begin
                pending = 1'b1;
                exp_word = w;
            end
            send(w, nb, 12);
        end
        tick(10);
        check("rb_valid", dout_valid, pending);
        check("rb_dout", dout, exp_word);
        check("rb_err", n_err - e0, exp_err);
        check("rb_ovr", n_ovr - o0, exp_ovr);
        dout_ready = 1'b1;
        tick(3);
        check("rb_drain", got_q[$], exp_word);
        check("rb_empty", dout_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Receive-side SPI stage that sits directly downstream of the 12-bit SPI master transmitter. It consumes the transmitter's sclk/cs/mosi lines and reconstructs each LSB-first frame in the system clock domain. Each frame is presented as a parallel word on a valid/ready output. Short, long and unconsumed frames are flagged.

Parameters:
DATA_W, 12, frame payload width in bits.
LEAD_EDGES, 1, sclk falling edges ignored after cs falls, before the first data bit.
SYNC_STAGES, 2, synchroniser depth on sclk, cs and mosi (minimum 2).

Ports:
clk  input  1  system clock (same clock that drives the master).
rst_n  input  1  asynchronous active-low reset.
sclk  input  1  serial clock from master.
cs  input  1  chip select from master, active low.
mosi  input  1  serial data from master, LSB first.
dout  output  DATA_W  received word; held stable while dout_valid is high.
dout_valid  output  1  received word available.
dout_ready  input  1  consumer accepts dout when high together with dout_valid.
frame_err  output  1  one-clk pulse when a frame ends with a bit count other than DATA_W.
overrun  output  1  one-clk pulse when a good frame completes while the previous word is still unconsumed.

Behaviour:
- Reset (async assert, sync release):
  - dout = 0, dout_valid = 0, frame_err = 0, overrun = 0.
  - Shift register, bit counter and lead counter cleared; FSM in IDLE.
  - Synchroniser and edge-detect flops for sclk, cs and mosi reset to 0.
- Synchronisation:
  - sclk, cs and mosi each pass through SYNC_STAGES flops plus one history flop.
  - Edges are detected from the synchronised value and its history.
  - sclk high and low phases must each last at least SYNC_STAGES+2 clk. The master's 11-clk phases satisfy this.
- FSM states:
  - IDLE: a synchronised cs falling edge moves to LEAD. Lead counter = 0, bit counter = 0.
    - cs rising edges and sclk edges in IDLE are ignored.
    - A cs that is already low out of reset is not a start, because the sync flops reset to 0.
  - LEAD: each sclk falling edge increments the lead counter. At LEAD_EDGES, go to SHIFT.
    - If LEAD_EDGES = 0, go from IDLE directly to SHIFT.
  - SHIFT: each sclk falling edge shifts synchronised mosi in LSB-first: shreg <= {mosi, shreg[DATA_W-1:1]}.
    - bit counter increments and saturates at DATA_W+1.
  - END: entered on a synchronised cs rising edge from LEAD or SHIFT. Evaluated in the next clk, then return to IDLE.
- Frame outcomes, decided in the END cycle:
  - bit counter == DATA_W, and dout_valid == 0 or dout_ready == 1: dout <= shreg, dout_valid <= 1.
  - bit counter == DATA_W, dout_valid == 1, dout_ready == 0: frame dropped, dout unchanged, overrun pulse.
  - bit counter != DATA_W (short, long, or ended in LEAD): frame dropped, frame_err pulse, dout/dout_valid unchanged.
- Output handshake:
  - dout_valid clears on the clk after dout_valid && dout_ready, unless reloaded in that same cycle.
  - If accept and reload coincide, the new word loads and dout_valid stays high with no gap and no overrun.
- Latency: dout_valid rises exactly 2 clk after the cycle in which the synchronised cs rising edge is visible. That is at most SYNC_STAGES+3 clk after the cs pin rises.
- Back-to-back frames: a cs falling edge seen in the END cycle is honoured. END transitions directly to LEAD in that case, so no frame is lost.
- Reset mid-frame: the partial frame is discarded and no pulse is issued. Reception resumes only after a fresh cs falling edge.
- frame_err and overrun are mutually exclusive single-cycle pulses.

Test Plan:
1. Master sends 12'hA5C, dout_ready held 1 -> one dout_valid pulse with dout = 12'hA5C; frame_err = 0, overrun = 0.
2. Bench drives cs low, 1 lead + 7 sclk falling edges, then cs high -> frame_err pulses once; dout_valid stays 0; the next 12'h3C3 frame is received correctly.
3. Two frames 12'h001 then 12'hFFF with dout_ready = 0 -> dout = 12'h001 and dout_valid stays 1; overrun pulses at the end of the second frame; after dout_ready = 1, dout_valid drops.
4. Word 12'h123 pending; dout_ready asserted in exactly the END cycle of frame 12'h456 -> dout = 12'h456, dout_valid stays continuously high, overrun = 0.
5. rst_n pulsed low after 5 bits of 12'hABC -> all outputs 0 immediately; no pulses; the following 12'h0F0 frame is received as 12'h0F0.
6. Reset released with cs held low mid-frame; frame tail clocked, then 12'h5A5 sent normally -> the tail produces nothing; exactly one dout_valid with dout = 12'h5A5.
